// File: rtl/wb_decoder_pkg.sv
// Shared types for the single-master, two-slave Wishbone decoder: bus bundles,
// FSM state encodings and the error response word.
`ifndef WB_DECODER_PKG_SV
`define WB_DECODER_PKG_SV

`define WB_M2S wb_decoder_pkg::wb_m2s_t
`define WB_S2M wb_decoder_pkg::wb_s2m_t

package wb_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S0_ACT  = 3'd1,
    S1_ACT  = 3'd2,
    ERR_ACK = 3'd3,
    DRAIN   = 3'd4
  } wb_dec_state_e;

  localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_m2s_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_s2m_t;

endpackage

`endif

// File: rtl/wb_decoder_addr_match.sv
// Masked address compare used once per slave window.
module wb_addr_match (
  input  logic [31:0] adr,
  input  logic [31:0] base,
  input  logic [31:0] mask,
  output logic        hit
);

  assign hit = ((adr & mask) == base);

endmodule

// File: rtl/wb_decoder.sv
// One-master, two-slave Wishbone decoder; optional stall timeout under WB_DEC_TIMEOUT_EN.
// state   | meaning
// IDLE    | no selection, decode on cyc&stb
// S0_ACT  | master bridged to slave 0
// S1_ACT  | master bridged to slave 1
// ERR_ACK | one-cycle error ack to master
// DRAIN   | wait for master to end the cycle
module wb_decoder
  import wb_decoder_pkg::*;
#(
  parameter logic [31:0] S0_BASE     = 32'h0000_0000,
  parameter logic [31:0] S0_MASK     = 32'hF000_0000,
  parameter logic [31:0] S1_BASE     = 32'h1000_0000,
  parameter logic [31:0] S1_MASK     = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  wb_m2s_t i_m2s_wb,
  output wb_s2m_t o_s2m_wb,
  output wb_m2s_t o_m2s0_wb,
  output wb_m2s_t o_m2s1_wb,
  input  wb_s2m_t i_s2m0_wb,
  input  wb_s2m_t i_s2m1_wb,
  output logic    o_err
);

  wb_dec_state_e state_q, state_d;
  logic          hit0, hit1;
  logic          req;
  logic          tmo_hit;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("wb_decoder: TIMEOUT_CYC must be at least 1");
  end

  assign req = i_m2s_wb.cyc & i_m2s_wb.stb;

  wb_addr_match u_match0 (
    .adr  (i_m2s_wb.adr),
    .base (S0_BASE),
    .mask (S0_MASK),
    .hit  (hit0)
  );

  wb_addr_match u_match1 (
    .adr  (i_m2s_wb.adr),
    .base (S1_BASE),
    .mask (S1_MASK),
    .hit  (hit1)
  );

`ifdef WB_DEC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             active;
  logic             sel_ack;

  assign active  = (state_q == S0_ACT) || (state_q == S1_ACT);
  assign sel_ack = (state_q == S0_ACT) ? i_s2m0_wb.ack : i_s2m1_wb.ack;
  assign tmo_hit = active && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));

  // Any state other than an active bridge holds the counter at zero, so entry always starts clean.
  always_comb begin
    tmo_cnt_d = '0;
    if (active) begin
      if (sel_ack || !i_m2s_wb.stb) begin
        tmo_cnt_d = '0;
      end else if (!tmo_hit) begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_d = tmo_cnt_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit0)      state_d = S0_ACT;
          else if (hit1) state_d = S1_ACT;
          else           state_d = ERR_ACK;
        end
      end
      S0_ACT, S1_ACT: begin
        if (!i_m2s_wb.cyc) state_d = IDLE;
        else if (tmo_hit)  state_d = ERR_ACK;
      end
      ERR_ACK: state_d = DRAIN;
      DRAIN:   if (!i_m2s_wb.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bridging is combinational on the registered selection, so reset drops slave cyc immediately.
  always_comb begin
    o_m2s0_wb = '0;
    o_m2s1_wb = '0;
    o_s2m_wb  = '0;
    o_err     = 1'b0;
    case (state_q)
      S0_ACT: begin
        if (!tmo_hit) begin
          o_m2s0_wb = i_m2s_wb;
          o_s2m_wb  = i_s2m0_wb;
        end
      end
      S1_ACT: begin
        if (!tmo_hit) begin
          o_m2s1_wb = i_m2s_wb;
          o_s2m_wb  = i_s2m1_wb;
        end
      end
      ERR_ACK: begin
        o_s2m_wb.ack = 1'b1;
        o_s2m_wb.dat = WB_ERR_DATA;
        o_err        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
